// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and the branch-control state type.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } br_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolve, PC redirect / IF-ID flush sequencing, perf counters.
// state    | meaning
// IDLE     | accepting resolve events, no flush
// REDIRECT | one cycle: pc_sel and both flushes asserted
// SQUASH   | flushes held until the flush counter runs out (frozen by stall)
module branch_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             stall,
  input  logic             br_less,
  input  logic             br_equal,
  input  logic             cnt_clr,
  output logic             br_un,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             flush_if,
  output logic             flush_id,
  output logic             illegal_br,
  output logic             busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_t       r_state;
  logic [2:0]      r_flush_cnt;
  logic [XLEN-1:0] r_pc_target;
  logic            r_illegal;

  logic w_cond_taken;
  logic w_illegal_f3;
  logic w_resolve;
  logic w_cond;
  logic w_take;
  logic w_br_inc;
  logic w_tk_inc;

  assign br_un = ex_funct3[1];

  always_comb begin
    w_cond_taken = 1'b0;
    w_illegal_f3 = 1'b0;
    case (ex_funct3)
      F3_BEQ:  w_cond_taken = br_equal;
      F3_BNE:  w_cond_taken = !br_equal;
      F3_BLT:  w_cond_taken = br_less;
      F3_BGE:  w_cond_taken = !br_less;
      F3_BLTU: w_cond_taken = br_less;
      F3_BGEU: w_cond_taken = !br_less;
      default: w_illegal_f3 = 1'b1;
    endcase
  end

  // Only IDLE resolves; anything presented while busy is wrong-path.
  assign w_resolve = (r_state == IDLE) && ex_valid && !stall && (ex_is_branch || ex_is_jump);
  assign w_cond    = w_resolve && ex_is_branch && !ex_is_jump;
  assign w_take    = (w_resolve && ex_is_jump) || (w_cond && w_cond_taken && !w_illegal_f3);
  assign w_br_inc  = w_cond && !w_illegal_f3;
  assign w_tk_inc  = w_br_inc && w_cond_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= 3'd0;
      r_pc_target <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_cond && w_illegal_f3;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_state     <= REDIRECT;
            r_pc_target <= ex_target;
          end
        end
        REDIRECT: begin
          if (FLUSH_CYCLES == 1) begin
            r_state <= IDLE;
          end else begin
            r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
            r_state     <= SQUASH;
          end
        end
        SQUASH: begin
          if (!stall) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
            if (r_flush_cnt == 3'd1) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc_sel     = (r_state == REDIRECT);
  assign flush_if   = (r_state != IDLE);
  assign flush_id   = (r_state != IDLE);
  assign busy       = (r_state != IDLE);
  assign pc_target  = r_pc_target;
  assign illegal_br = r_illegal;

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (cnt_clr),
    .i_inc   (w_br_inc),
    .o_count (br_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (cnt_clr),
    .i_inc   (w_tk_inc),
    .o_count (taken_cnt)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: redirect timing, decode, stall, wrong-path, reset, clear.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_target;
  logic        stall, br_less, br_equal, cnt_clr;
  logic        br_un, pc_sel, flush_if, flush_id, illegal_br, busy;
  logic [31:0] pc_target, br_cnt, taken_cnt;

  int checks   = 0;
  int failures = 0;

  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_target(ex_target),
    .stall(stall), .br_less(br_less), .br_equal(br_equal), .cnt_clr(cnt_clr),
    .br_un(br_un), .pc_sel(pc_sel), .pc_target(pc_target), .flush_if(flush_if),
    .flush_id(flush_id), .illegal_br(illegal_br), .busy(busy),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ps, input logic fl,
                         input logic [31:0] bc, input logic [31:0] tc);
    chk({tag, "_pc_sel"}, {31'd0, pc_sel}, {31'd0, ps});
    chk({tag, "_flush_if"}, {31'd0, flush_if}, {31'd0, fl});
    chk({tag, "_flush_id"}, {31'd0, flush_id}, {31'd0, fl});
    chk({tag, "_br_cnt"}, br_cnt, bc);
    chk({tag, "_taken_cnt"}, taken_cnt, tc);
  endtask

  task automatic branch(input logic [2:0] f3, input logic lt, input logic eq,
                        input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jump = 1'b0;
    ex_funct3 = f3; br_less = lt; br_equal = eq; ex_target = tgt;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; cnt_clr = 1'b0;
    ex_funct3 = 3'b000; br_less = 1'b0; br_equal = 1'b0; ex_target = 32'd0;
    idle_in();
    #12;
    chk_out("reset", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_pc_target", pc_target, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_br}, 32'd0);
    rst_n = 1'b1;
    step();

    // BEQ taken, two flush cycles
    branch(3'b000, 1'b0, 1'b1, 32'h0000_0100);
    #1 chk("beq_br_un", {31'd0, br_un}, 32'd0);
    step(); idle_in();
    chk_out("beq_t1", 1'b1, 1'b1, 32'd1, 32'd1);
    chk("beq_target", pc_target, 32'h100);
    step();
    chk_out("beq_t2", 1'b0, 1'b1, 32'd1, 32'd1);
    step();
    chk_out("beq_t3", 1'b0, 1'b0, 32'd1, 32'd1);
    chk("beq_busy_done", {31'd0, busy}, 32'd0);

    // BLT signed taken, then BLTU same operands not taken
    branch(3'b100, 1'b1, 1'b0, 32'h0000_0200);
    #1 chk("blt_br_un", {31'd0, br_un}, 32'd0);
    step(); idle_in();
    chk_out("blt_t1", 1'b1, 1'b1, 32'd2, 32'd2);
    step(); step();
    branch(3'b110, 1'b0, 1'b0, 32'h0000_0300);
    #1 chk("bltu_br_un", {31'd0, br_un}, 32'd1);
    step(); idle_in();
    chk_out("bltu_nt", 1'b0, 1'b0, 32'd3, 32'd2);
    chk("bltu_busy", {31'd0, busy}, 32'd0);

    // illegal funct3
    branch(3'b010, 1'b1, 1'b1, 32'h0000_0400);
    step(); idle_in();
    chk("ill_pulse", {31'd0, illegal_br}, 32'd1);
    chk_out("ill_nored", 1'b0, 1'b0, 32'd3, 32'd2);
    step();
    chk("ill_pulse_end", {31'd0, illegal_br}, 32'd0);

    // BNE taken, wrong-path branches while busy, stall in SQUASH
    branch(3'b001, 1'b0, 1'b0, 32'h0000_0300);
    step();
    branch(3'b001, 1'b0, 1'b0, 32'h0000_0999);
    chk_out("bne_t1", 1'b1, 1'b1, 32'd4, 32'd3);
    step();
    stall = 1'b1;
    chk_out("bne_sq", 1'b0, 1'b1, 32'd4, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bne_stall", 1'b0, 1'b1, 32'd4, 32'd3);
    end
    chk("bne_target_kept", pc_target, 32'h300);
    chk("bne_no_ill", {31'd0, illegal_br}, 32'd0);
    stall = 1'b0; idle_in();
    step();
    chk_out("bne_done", 1'b0, 1'b0, 32'd4, 32'd3);

    // JAL held by stall, then a single redirect
    ex_valid = 1'b1; ex_is_jump = 1'b1; ex_is_branch = 1'b0;
    ex_target = 32'h0000_0ABC; stall = 1'b1;
    step();
    chk("jal_stall1_busy", {31'd0, busy}, 32'd0);
    step();
    chk("jal_stall2_busy", {31'd0, busy}, 32'd0);
    stall = 1'b0;
    step(); idle_in();
    chk_out("jal_t1", 1'b1, 1'b1, 32'd4, 32'd3);
    chk("jal_target", pc_target, 32'hABC);
    step(); step();
    chk("jal_done", {31'd0, busy}, 32'd0);

    // jump and branch both set: jump wins, no count
    branch(3'b010, 1'b0, 1'b0, 32'h0000_0044);
    ex_is_jump = 1'b1;
    step(); idle_in();
    chk_out("both_t1", 1'b1, 1'b1, 32'd4, 32'd3);
    chk("both_no_ill", {31'd0, illegal_br}, 32'd0);
    step(); step();

    // reset during SQUASH
    branch(3'b000, 1'b0, 1'b1, 32'h0000_0500);
    step(); idle_in();
    chk_out("rst_pre", 1'b1, 1'b1, 32'd5, 32'd4);
    step();
    #2 rst_n = 1'b0;
    #1 chk_out("rst_mid", 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_mid_target", pc_target, 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk_out("rst_after", 1'b0, 1'b0, 32'd0, 32'd0);

    // cnt_clr beats an increment from a taken branch
    branch(3'b101, 1'b0, 1'b0, 32'h0000_0600);
    step(); idle_in();
    chk_out("clr_pre", 1'b1, 1'b1, 32'd1, 32'd1);
    step(); step();
    branch(3'b111, 1'b0, 1'b0, 32'h0000_0700);
    cnt_clr = 1'b1;
    step(); idle_in(); cnt_clr = 1'b0;
    chk_out("clr_taken", 1'b1, 1'b1, 32'd0, 32'd0);
    chk("clr_target", pc_target, 32'h700);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
